// File: rtl/fft_bfp_scale_ctrl_if.sv
// Sample stream into the BFP scaling controller: valid/data/last from the
// stage memory side, ready back from the controller.
interface fft_bfp_scale_ctrl_if #(
  parameter int DATA_W = 32
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              in_ready;

  modport master (
    output in_valid,
    output in_data,
    output in_last,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_last,
    output in_ready
  );
endinterface

// File: rtl/fft_bfp_scale_ctrl.sv
// Block-floating-point scaling controller for the radix-2 FFT.
// Scans every sample entering a stage, finds the worst-case headroom need,
// turns it into the stage's right-shift and accumulates a saturating block
// exponent across the whole transform.
module fft_bfp_scale_ctrl #(
  parameter int DATA_W     = 32,
  parameter int NUM_STAGES = 5,
  parameter int EXP_W      = 4,
  parameter int MAX_SHIFT  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  fft_bfp_scale_ctrl_if.slave  s_in,
  output logic [1:0]           shift_amt,
  output logic                 shift_valid,
  output logic [2:0]           stage_idx,
  output logic [EXP_W-1:0]     exp_out,
  output logic                 exp_sat,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_DECIDE,
    S_DONE
  } state_t;

  localparam logic [1:0]       MAX_SHIFT_L = MAX_SHIFT[1:0];
  localparam logic [2:0]       LAST_STAGE  = 3'(NUM_STAGES - 1);
  localparam logic [EXP_W:0]   EXP_MAX     = {1'b0, {EXP_W{1'b1}}};

  state_t             state_q, state_d;
  logic [2:0]         stage_idx_q, stage_idx_d;
  logic [1:0]         max_need_q, max_need_d;
  logic [1:0]         shift_amt_q, shift_amt_d;
  logic               shift_valid_q, shift_valid_d;
  logic [EXP_W-1:0]   exp_q, exp_d;
  logic               exp_sat_q, exp_sat_d;

  logic [1:0]         re_need, im_need, sample_need, shift_new;
  logic [EXP_W:0]     exp_sum;
  logic               accept;

  // Headroom a 16-bit half needs: 2 if the top two bits disagree, 1 if the
  // next pair disagrees, otherwise the value already fits two shifts.
  function automatic logic [1:0] half_need(input logic [15:0] h);
    logic [1:0] n;
    if (h[15] ^ h[14]) begin
      n = 2'd2;
    end else if (h[14] ^ h[13]) begin
      n = 2'd1;
    end else begin
      n = 2'd0;
    end
    return n;
  endfunction

  // Per-sample need, clamped shift and widened exponent sum used by the FSM.
  always_comb begin
    re_need     = half_need(s_in.in_data[DATA_W-1 -: 16]);
    im_need     = half_need(s_in.in_data[15:0]);
    sample_need = (re_need > im_need) ? re_need : im_need;
    shift_new   = (max_need_q > MAX_SHIFT_L) ? MAX_SHIFT_L : max_need_q;
    exp_sum     = {1'b0, exp_q} + {{(EXP_W-1){1'b0}}, shift_new};
    accept      = s_in.in_valid && (state_q == S_SCAN);
  end

  // Next-state and register updates for the IDLE/SCAN/DECIDE/DONE sequence.
  always_comb begin
    state_d       = state_q;
    stage_idx_d   = stage_idx_q;
    max_need_d    = max_need_q;
    shift_amt_d   = shift_amt_q;
    shift_valid_d = 1'b0;
    exp_d         = exp_q;
    exp_sat_d     = exp_sat_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_SCAN;
          stage_idx_d = '0;
          exp_d       = '0;
          exp_sat_d   = 1'b0;
          max_need_d  = '0;
        end
      end
      S_SCAN: begin
        if (accept) begin
          if (sample_need > max_need_q) begin
            max_need_d = sample_need;
          end
          if (s_in.in_last) begin
            state_d = S_DECIDE;
          end
        end
      end
      S_DECIDE: begin
        shift_amt_d   = shift_new;
        shift_valid_d = 1'b1;
        max_need_d    = '0;
        if (exp_sum > EXP_MAX) begin
          exp_d     = EXP_MAX[EXP_W-1:0];
          exp_sat_d = 1'b1;
        end else begin
          exp_d = exp_sum[EXP_W-1:0];
        end
        if (stage_idx_q == LAST_STAGE) begin
          state_d = S_DONE;
        end else begin
          stage_idx_d = stage_idx_q + 3'd1;
          state_d     = S_SCAN;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and result registers with synchronous reset back to IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      stage_idx_q   <= '0;
      max_need_q    <= '0;
      shift_amt_q   <= '0;
      shift_valid_q <= 1'b0;
      exp_q         <= '0;
      exp_sat_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      stage_idx_q   <= stage_idx_d;
      max_need_q    <= max_need_d;
      shift_amt_q   <= shift_amt_d;
      shift_valid_q <= shift_valid_d;
      exp_q         <= exp_d;
      exp_sat_q     <= exp_sat_d;
    end
  end

  assign s_in.in_ready = (state_q == S_SCAN);
  assign shift_amt     = shift_amt_q;
  assign shift_valid   = shift_valid_q;
  assign stage_idx     = stage_idx_q;
  assign exp_out       = exp_q;
  assign exp_sat       = exp_sat_q;
  assign busy          = (state_q != S_IDLE);
  assign done          = (state_q == S_DONE);

endmodule

// File: tb/tb_fft_bfp_scale_ctrl.sv
// Bench for fft_bfp_scale_ctrl: two instances (EXP_W=4 and EXP_W=3) driven
// with identical streams; table vectors, hand sequences and random stages
// checked against an arithmetic reference model.
module tb_fft_bfp_scale_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic start;

  always #5 clk = ~clk;

  fft_bfp_scale_ctrl_if #(.DATA_W(32)) bus4 ();
  fft_bfp_scale_ctrl_if #(.DATA_W(32)) bus3 ();

  logic [1:0] shift_amt4, shift_amt3;
  logic       shift_valid4, shift_valid3;
  logic [2:0] stage_idx4, stage_idx3;
  logic [3:0] exp_out4;
  logic [2:0] exp_out3;
  logic       exp_sat4, exp_sat3;
  logic       busy4, busy3;
  logic       done4, done3;

  fft_bfp_scale_ctrl #(.DATA_W(32), .NUM_STAGES(5), .EXP_W(4), .MAX_SHIFT(2)) dut4 (
    .clk(clk), .rst(rst), .start(start), .s_in(bus4.slave),
    .shift_amt(shift_amt4), .shift_valid(shift_valid4), .stage_idx(stage_idx4),
    .exp_out(exp_out4), .exp_sat(exp_sat4), .busy(busy4), .done(done4)
  );

  fft_bfp_scale_ctrl #(.DATA_W(32), .NUM_STAGES(5), .EXP_W(3), .MAX_SHIFT(2)) dut3 (
    .clk(clk), .rst(rst), .start(start), .s_in(bus3.slave),
    .shift_amt(shift_amt3), .shift_valid(shift_valid3), .stage_idx(stage_idx3),
    .exp_out(exp_out3), .exp_sat(exp_sat3), .busy(busy3), .done(done3)
  );

  int checks = 0;
  int errors = 0;

  // reference model state
  int m_need, m_exp4, m_exp3, m_sat4, m_sat3;
  int e_shift;

  typedef struct {
    logic [31:0] data;
    int          nrep;
    int          shift;
    int          exp4;
    int          sat4;
    int          exp3;
    int          sat3;
  } vec_t;

  vec_t tbl [15];

  task automatic checkOutput(input string name, input logic [31:0] act, input int req);
    checks++;
    if (act !== 32'(req)) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // need of one signed half from its magnitude range
  function automatic int half_need_model(input logic [15:0] h);
    int v;
    v = int'($signed(h));
    if (v > 16383 || v < -16384) return 2;
    if (v > 8191 || v < -8192) return 1;
    return 0;
  endfunction

  function automatic int sample_need_model(input logic [31:0] d);
    int a, b;
    a = half_need_model(d[31:16]);
    b = half_need_model(d[15:0]);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [31:0] rand_sample();
    logic signed [15:0] a, b;
    a = 16'($urandom);
    b = 16'($urandom);
    a = a >>> $urandom_range(0, 3);
    b = b >>> $urandom_range(0, 3);
    return {a, b};
  endfunction

  task automatic drive(input logic v, input logic [31:0] d, input logic l);
    bus4.in_valid = v; bus4.in_data = d; bus4.in_last = l;
    bus3.in_valid = v; bus3.in_data = d; bus3.in_last = l;
  endtask

  task automatic model_clear();
    m_need = 0; m_exp4 = 0; m_exp3 = 0; m_sat4 = 0; m_sat3 = 0;
  endtask

  // close a stage in the model: clamp the need, add with saturation
  task automatic model_stage();
    e_shift = (m_need > 2) ? 2 : m_need;
    if (m_exp4 + e_shift > 15) begin m_exp4 = 15; m_sat4 = 1; end
    else m_exp4 = m_exp4 + e_shift;
    if (m_exp3 + e_shift > 7) begin m_exp3 = 7; m_sat3 = 1; end
    else m_exp3 = m_exp3 + e_shift;
    m_need = 0;
  endtask

  task automatic applyStimulus(input logic [31:0] d, input logic l, input bit hold);
    int budget;
    budget = 0;
    @(negedge clk);
    start = 1'b0;
    drive(1'b1, d, l);
    while (!bus4.in_ready && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    if (!bus4.in_ready) begin
      checks++;
      errors++;
      $display("[TB] FAIL ready_timeout actual=0 required=1");
    end
    @(posedge clk);
    if (sample_need_model(d) > m_need) m_need = sample_need_model(d);
    if (!hold) begin
      #1 drive(1'b0, 32'h0, 1'b0);
    end
  endtask

  task automatic gap(input int n);
    repeat (n) begin
      @(negedge clk);
      drive(1'b0, $urandom, 1'($urandom_range(0, 1)));
      start = ($urandom_range(0, 7) == 0);
    end
  endtask

  task automatic start_transform();
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    model_clear();
    checkOutput("start_ready", bus4.in_ready, 1);
    checkOutput("start_busy", busy3, 1);
    checkOutput("start_stage", stage_idx4, 0);
    checkOutput("start_exp4", exp_out4, 0);
    checkOutput("start_exp3", exp_out3, 0);
    checkOutput("start_sat4", exp_sat4, 0);
    checkOutput("start_sat3", exp_sat3, 0);
  endtask

  // called right after the posedge that accepted the stage's last sample
  task automatic stage_end(input int s, input int sh, input int x4, input int st4,
                           input int x3, input int st3);
    bit last;
    last = (s == 4);
    @(negedge clk);
    checkOutput("decide_ready", bus4.in_ready, 0);
    checkOutput("decide_ready3", bus3.in_ready, 0);
    checkOutput("decide_svalid", shift_valid4, 0);
    @(negedge clk);
    checkOutput("svalid", shift_valid4, 1);
    checkOutput("shift_amt4", shift_amt4, sh);
    checkOutput("shift_amt3", shift_amt3, sh);
    checkOutput("exp_out4", exp_out4, x4);
    checkOutput("exp_sat4", exp_sat4, st4);
    checkOutput("exp_out3", exp_out3, x3);
    checkOutput("exp_sat3", exp_sat3, st3);
    checkOutput("done", done4, int'(last));
    checkOutput("stage_idx", stage_idx4, last ? 4 : s + 1);
    checkOutput("ready_after", bus4.in_ready, int'(!last));
    if (last) begin
      @(negedge clk);
      checkOutput("done_pulse_end", done4, 0);
      checkOutput("idle_busy", busy4, 0);
      checkOutput("idle_svalid", shift_valid3, 0);
      checkOutput("held_exp4", exp_out4, x4);
      checkOutput("held_shift", shift_amt4, sh);
    end
  endtask

  task automatic random_stage(input int s);
    int n;
    n = $urandom_range(1, 6);
    for (int i = 0; i < n; i++) begin
      gap($urandom_range(0, 2));
      applyStimulus(rand_sample(), 1'(i == n - 1), 1'b0);
    end
    model_stage();
    stage_end(s, e_shift, m_exp4, m_sat4, m_exp3, m_sat3);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    start = 1'b0;
    drive(1'b0, 32'h0, 1'b0);
    repeat (2) @(negedge clk);
    checkOutput("rst_ready", bus4.in_ready, 0);
    checkOutput("rst_busy", busy4, 0);
    checkOutput("rst_shift", shift_amt4, 0);
    checkOutput("rst_svalid", shift_valid4, 0);
    checkOutput("rst_exp4", exp_out4, 0);
    checkOutput("rst_exp3", exp_out3, 0);
    checkOutput("rst_sat3", exp_sat3, 0);
    checkOutput("rst_done", done4, 0);
    checkOutput("rst_stage", stage_idx4, 0);
    rst = 1'b0;
    model_clear();
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b0;
    start = 1'b0;
    drive(1'b0, 32'h0, 1'b0);

    // quiet transform, decode transform, saturating transform
    tbl[0]  = '{32'h0025_0124, 4, 0, 0, 0, 0, 0};
    tbl[1]  = '{32'h0025_0124, 4, 0, 0, 0, 0, 0};
    tbl[2]  = '{32'h0025_0124, 4, 0, 0, 0, 0, 0};
    tbl[3]  = '{32'h0025_0124, 4, 0, 0, 0, 0, 0};
    tbl[4]  = '{32'h0025_0124, 4, 0, 0, 0, 0, 0};
    tbl[5]  = '{32'h4000_0000, 1, 2, 2, 0, 2, 0};
    tbl[6]  = '{32'h0000_D000, 1, 1, 3, 0, 3, 0};
    tbl[7]  = '{32'hE000_1FFF, 1, 0, 3, 0, 3, 0};
    tbl[8]  = '{32'h0025_0124, 2, 0, 3, 0, 3, 0};
    tbl[9]  = '{32'hC000_2000, 3, 1, 4, 0, 4, 0};
    tbl[10] = '{32'h4000_4000, 1, 2, 2, 0, 2, 0};
    tbl[11] = '{32'h4000_4000, 2, 2, 4, 0, 4, 0};
    tbl[12] = '{32'h4000_4000, 1, 2, 6, 0, 6, 0};
    tbl[13] = '{32'h4000_4000, 1, 2, 8, 0, 7, 1};
    tbl[14] = '{32'h4000_4000, 2, 2, 10, 0, 7, 1};

    do_reset();

    for (int t = 0; t < 3; t++) begin
      start_transform();
      for (int s = 0; s < 5; s++) begin
        for (int r = 0; r < tbl[t*5+s].nrep; r++) begin
          applyStimulus(tbl[t*5+s].data, 1'(r == tbl[t*5+s].nrep - 1), 1'b0);
        end
        model_stage();
        stage_end(s, tbl[t*5+s].shift, tbl[t*5+s].exp4, tbl[t*5+s].sat4,
                  tbl[t*5+s].exp3, tbl[t*5+s].sat3);
      end
    end

    // restart after saturation clears exponent; then handshake corners
    start_transform();
    repeat (3) begin
      @(negedge clk);
      drive(1'b0, 32'h7FFF_7FFF, 1'b1);
      checkOutput("lastnv_ready", bus4.in_ready, 1);
      checkOutput("lastnv_svalid", shift_valid4, 0);
      checkOutput("lastnv_stage", stage_idx4, 0);
    end
    applyStimulus(32'h4000_0000, 1'b1, 1'b1);
    model_stage();
    stage_end(0, e_shift, m_exp4, m_sat4, m_exp3, m_sat3);
    drive(1'b0, 32'h0, 1'b0);
    applyStimulus(32'h0025_0124, 1'b1, 1'b0);
    model_stage();
    stage_end(1, e_shift, m_exp4, m_sat4, m_exp3, m_sat3);
    for (int s = 2; s < 5; s++) random_stage(s);

    // random transforms against the model
    for (int t = 0; t < 6; t++) begin
      start_transform();
      for (int s = 0; s < 5; s++) random_stage(s);
    end

    // reset in the middle of stage 2, then a clean transform
    start_transform();
    random_stage(0);
    random_stage(1);
    applyStimulus(32'h4000_4000, 1'b0, 1'b0);
    applyStimulus(32'h0000_0100, 1'b0, 1'b0);
    do_reset();
    start_transform();
    for (int s = 0; s < 5; s++) random_stage(s);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
